// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
package tt_sweep_pkg;

    typedef enum logic [1:0] {StIdle, StApply, StSample, StFin} state_e;

    localparam int unsigned NUM_VEC = 4;

    // Sweep order maps the vector index straight onto {x1,x2}.
    function automatic logic [1:0] idx_to_inputs(input logic [1:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Settle-time counter: counts while enabled, flags the last hold cycle and wraps to zero.
module hold_timer
    import tt_sweep_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned CNT_W       = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Drives a 2-input block through 00,01,10,11, captures z per vector and
// compares the captured table against a truth table latched at start.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [3:0] i_exp_tt,
    output logic       o_x1,
    output logic       o_x2,
    input  logic       i_z,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_result,
    output logic       o_pass,
    output logic       o_err,
    output logic [1:0] o_err_idx
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_VEC - 1);

    state_e     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_exp;
    logic       w_tc;
    logic       w_en;
    logic       w_clr;
    logic       w_mis;

    assign w_en  = (r_state == StApply);
    assign w_clr = (r_state != StApply);
    assign w_mis = (i_z != r_exp[r_idx]);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_clr),
        .i_en  (w_en),
        .o_tc  (w_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_idx     <= 2'd0;
            r_exp     <= 4'd0;
            o_x1      <= 1'b0;
            o_x2      <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_result  <= 4'd0;
            o_pass    <= 1'b0;
            o_err     <= 1'b0;
            o_err_idx <= 2'd0;
        end else begin
            o_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_exp        <= i_exp_tt;
                        o_result     <= 4'd0;
                        o_pass       <= 1'b0;
                        o_err        <= 1'b0;
                        o_err_idx    <= 2'd0;
                        r_idx        <= 2'd0;
                        {o_x1, o_x2} <= idx_to_inputs(2'd0);
                        o_busy       <= 1'b1;
                        r_state      <= StApply;
                    end
                end
                StApply: begin
                    if (i_abort) begin
                        {o_x1, o_x2} <= 2'b00;
                        o_busy       <= 1'b0;
                        o_pass       <= 1'b0;
                        r_state      <= StIdle;
                    end else if (w_tc) begin
                        r_state <= StSample;
                    end
                end
                StSample: begin
                    // Abort wins over the capture of this vector.
                    if (i_abort) begin
                        {o_x1, o_x2} <= 2'b00;
                        o_busy       <= 1'b0;
                        o_pass       <= 1'b0;
                        r_state      <= StIdle;
                    end else begin
                        o_result[r_idx] <= i_z;
                        if (w_mis && !o_err) begin
                            o_err     <= 1'b1;
                            o_err_idx <= r_idx;
                        end
                        if (r_idx == LAST_IDX) begin
                            {o_x1, o_x2} <= 2'b00;
                            o_done       <= 1'b1;
                            o_pass       <= !(o_err || w_mis);
                            r_state      <= StFin;
                        end else begin
                            r_idx        <= r_idx + 2'd1;
                            {o_x1, o_x2} <= idx_to_inputs(r_idx + 2'd1);
                            r_state      <= StApply;
                        end
                    end
                end
                StFin: begin
                    o_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
